// File: rtl/microwave_display.sv
// rtl/microwave_display.sv - cook-time seconds to multiplexed MM:SS 7-segment display
//
// Purpose: converts a binary seconds value to MM:SS (divide by 60, then BCD via
// double-dabble, both multi-cycle) and scans it onto a 4-digit common-anode
// 7-segment panel. Blinks "0:00" while done is high.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   time_in    remaining cook time, unsigned seconds
//   time_valid one-cycle load strobe for time_in
//   done       level, cook finished; display blinks "0:00"
//   busy       conversion in progress
//   overflow   last committed value was saturated to 99:59
//   seg        {g,f,e,d,c,b,a}, active-low
//   dp         colon after minute units, active-low
//   an         digit enables, active-low, an[3] = minute tens

module microwave_display #(
  parameter int TIME_W    = 16,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] time_in,
  input  logic              time_valid,
  input  logic              done,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [3:0]        an
);

  localparam int CNT_W   = (TIME_W > 8) ? $clog2(TIME_W) : 3;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {IDLE, DIV, BCD, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIME_W-1:0]  quo_q, quo_d;
  logic [5:0]         rem_q, rem_d;
  logic               sat_q, sat_d;
  logic [14:0]        ddm_q, ddm_d;   // {bcd tens, bcd units, binary} for minutes
  logic [14:0]        dds_q, dds_d;   // same layout for seconds
  logic [15:0]        digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;
  logic [TIME_W-1:0]  pval_q, pval_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               vis_q, vis_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  logic [TIME_W-1:0]  operand;
  logic [6:0]         shifted;
  logic [3:0]         cur_digit;

  function automatic logic [14:0] dd_step(input logic [14:0] x);
    logic [14:0] y;
    y = x;
    if (y[10:7] >= 4'd5)  y[10:7]  = y[10:7] + 4'd3;
    if (y[14:11] >= 4'd5) y[14:11] = y[14:11] + 4'd3;
    return {y[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      sat_q    <= 1'b0;
      ddm_q    <= '0;
      dds_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      pval_q   <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      vis_q    <= 1'b1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      sat_q    <= sat_d;
      ddm_q    <= ddm_d;
      dds_q    <= dds_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      pval_q   <= pval_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      vis_q    <= vis_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  // Conversion FSM and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    sat_d    = sat_q;
    ddm_d    = ddm_q;
    dds_d    = dds_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    pval_d   = pval_q;
    // A fresh strobe in IDLE beats an older pending value.
    operand  = time_valid ? time_in : pval_q;
    shifted  = {rem_q, quo_q[TIME_W-1]};

    if (time_valid && (state_q != IDLE)) begin
      pend_d = 1'b1;
      pval_d = time_in;
    end

    case (state_q)
      IDLE: begin
        if (time_valid || pend_q) begin
          if (32'(operand) >= 32'd6000) begin
            quo_d = TIME_W'(5999);
            sat_d = 1'b1;
          end else begin
            quo_d = operand;
            sat_d = 1'b0;
          end
          rem_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        // Restoring divide: quotient bits shift in where the dividend shifts out.
        quo_d = {quo_q[TIME_W-2:0], (shifted >= 7'd60)};
        rem_d = (shifted >= 7'd60) ? 6'(shifted - 7'd60) : shifted[5:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TIME_W - 1)) begin
          cnt_d   = '0;
          state_d = BCD;
        end
      end
      BCD: begin
        // Count 0 loads the scratch registers; counts 1..7 are the shifts.
        if (cnt_q == '0) begin
          ddm_d = {8'h00, quo_q[6:0]};
          dds_d = {8'h00, 1'b0, rem_q};
        end else begin
          ddm_d = dd_step(ddm_q);
          dds_d = dd_step(dds_q);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        digits_d = {ddm_q[14:7], dds_q[14:7]};
        ovf_d    = sat_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan, blink and registered panel outputs
  always_comb begin
    scan_d  = scan_q + SCAN_W'(1);
    idx_d   = idx_q;
    blink_d = blink_q + BLINK_W'(1);
    vis_d   = vis_q;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    an_d    = 4'hF;

    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    // Held visible and at zero while done is low, so a rising done starts visible.
    if (!done) begin
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_d = '0;
      vis_d   = ~vis_q;
    end

    cur_digit = done ? 4'd0 : digits_q[idx_q*4 +: 4];
    if (!(done && !vis_q)) begin
      an_d  = ~(4'b0001 << idx_q);
      dp_d  = (idx_q != 2'd2);
      seg_d = ((idx_q == 2'd3) && (cur_digit == 4'd0)) ? 7'h7F : seg_enc(cur_digit);
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;

endmodule
